// File: rtl/la_capture_core.sv
// la_capture_core: multi-bit logic-analyser capture core with masked
// level/edge trigger, circular pre-trigger buffer and a valid/ready readout.
// Optional build macro LA_TRIG_COUNT_EN adds trig_cnt_i: the capture fires on
// trigger occurrence trig_cnt_i+1 seen in WAIT instead of the first one.
//
// state | meaning
// IDLE  | waiting for arm
// FILL  | writing the pre-trigger history, triggers ignored
// WAIT  | circular writes, looking for the trigger
// POST  | writing the remaining post-trigger samples
// DONE  | buffer valid, waiting for readout or re-arm
// READ  | streaming the buffer oldest-first
module la_capture_core #(
    parameter int DATA_W   = 8,
    parameter int TRIG_W   = 4,
    parameter int ADDR_W   = 9,
    parameter int PRE_TRIG = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              arm_i,
    input  logic              abort_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [TRIG_W-1:0] trig_i,
    input  logic [TRIG_W-1:0] trig_mask_i,
    input  logic [TRIG_W-1:0] trig_val_i,
    input  logic [TRIG_W-1:0] trig_edge_i,
`ifdef LA_TRIG_COUNT_EN
    input  logic [15:0]       trig_cnt_i,
`endif
    input  logic              rd_start_i,
    input  logic              rd_ready_i,
    output logic              rd_valid_o,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_last_o,
    output logic              busy_o,
    output logic              triggered_o,
    output logic              done_o,
    output logic [ADDR_W-1:0] trig_pos_o
);
    localparam int DEPTH    = 2**ADDR_W;
    localparam int POST_LEN = DEPTH - PRE_TRIG;
    localparam int RW       = ADDR_W + 1;

    localparam logic [ADDR_W-1:0] PRE_OFS  = ADDR_W'(PRE_TRIG);
    localparam logic [ADDR_W-1:0] FILL_LD  = ADDR_W'((PRE_TRIG > 0) ? PRE_TRIG - 1 : 0);
    // The trigger sample itself is one of the POST_LEN writes, so POST runs POST_LEN-1 cycles.
    localparam logic [ADDR_W-1:0] POST_LD  = ADDR_W'((POST_LEN > 1) ? POST_LEN - 2 : 0);
    localparam logic [RW-1:0]     RD_BEATS = RW'(DEPTH);
    localparam logic [RW-1:0]     RD_ONE   = RW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_WAIT,
        S_POST,
        S_DONE,
        S_READ
    } state_t;

    state_t state_q, state_d;

    logic [TRIG_W-1:0] trig_q;
    logic [TRIG_W-1:0] bit_hit;
    logic              trig_hit;
    logic              trig_take;

    logic [ADDR_W-1:0] wr_ptr_q;
    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W-1:0] trig_pos_q;
    logic              triggered_q;
    logic              done_q;
    logic              wr_en;

    logic              arm_go;
    logic              cap_go;
    logic              fin_go;
    logic              rd_go;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] rd_addr_q;
    logic [RW-1:0]     rd_left_q;
    logic              rd_valid_q;
    logic              rd_last_q;
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_load;

    // Unmasked bits must match the value; edge bits additionally need the previous sample to differ.
    assign bit_hit  = ~trig_mask_i
                    | (~(trig_i ^ trig_val_i) & (~trig_edge_i | (trig_q ^ trig_val_i)));
    assign trig_hit = &bit_hit;

`ifdef LA_TRIG_COUNT_EN
    logic [15:0] occ_q;

    assign trig_take = trig_hit && (occ_q == trig_cnt_i);

    // Count trigger occurrences in WAIT that are passed over as ordinary samples.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            occ_q <= '0;
        end else if (arm_go) begin
            occ_q <= '0;
        end else if ((state_q == S_WAIT) && trig_hit && !trig_take && !abort_i) begin
            occ_q <= occ_q + 16'd1;
        end
    end
`else
    assign trig_take = trig_hit;
`endif

    assign wr_en = (state_q == S_FILL) || (state_q == S_WAIT) || (state_q == S_POST);

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and single-cycle control strobes; abort overrides everything.
    always_comb begin
        state_d = state_q;
        arm_go  = 1'b0;
        cap_go  = 1'b0;
        fin_go  = 1'b0;
        rd_go   = 1'b0;
        if (abort_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (arm_i) begin
                        arm_go  = 1'b1;
                        state_d = (PRE_TRIG == 0) ? S_WAIT : S_FILL;
                    end
                end
                S_FILL: begin
                    if (cnt_q == '0) begin
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (trig_take) begin
                        cap_go = 1'b1;
                        if (POST_LEN == 1) begin
                            fin_go  = 1'b1;
                            state_d = S_DONE;
                        end else begin
                            state_d = S_POST;
                        end
                    end
                end
                S_POST: begin
                    if (cnt_q == '0) begin
                        fin_go  = 1'b1;
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    if (arm_i) begin
                        arm_go  = 1'b1;
                        state_d = (PRE_TRIG == 0) ? S_WAIT : S_FILL;
                    end else if (rd_start_i) begin
                        rd_go   = 1'b1;
                        state_d = S_READ;
                    end
                end
                S_READ: begin
                    if (rd_valid_q && rd_ready_i && rd_last_q) begin
                        state_d = S_DONE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Write pointer, phase down-counter, trigger position and status flags.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            trig_q      <= '0;
            wr_ptr_q    <= '0;
            cnt_q       <= '0;
            trig_pos_q  <= '0;
            triggered_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            trig_q <= trig_i;
            if (abort_i) begin
                triggered_q <= 1'b0;
                done_q      <= 1'b0;
            end else if (arm_go) begin
                wr_ptr_q    <= '0;
                cnt_q       <= FILL_LD;
                triggered_q <= 1'b0;
                done_q      <= 1'b0;
            end else begin
                if (wr_en) begin
                    wr_ptr_q <= wr_ptr_q + 1'b1;
                end
                if (cap_go) begin
                    trig_pos_q  <= wr_ptr_q;
                    triggered_q <= 1'b1;
                    cnt_q       <= POST_LD;
                end else if ((state_q == S_FILL) || (state_q == S_POST)) begin
                    cnt_q <= cnt_q - 1'b1;
                end
                if (fin_go) begin
                    done_q <= 1'b1;
                end
            end
        end
    end

    // Capture buffer write port; contents are not reset.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= data_i;
        end
    end

    // A new word is fetched whenever the output register is empty or being consumed.
    assign rd_load = (state_q == S_READ) && (!rd_valid_q || rd_ready_i);

    // Readout: synchronous buffer read straight into the output register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_addr_q  <= '0;
            rd_left_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            rd_data_q  <= '0;
        end else if (abort_i) begin
            rd_left_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
        end else if (rd_go) begin
            rd_addr_q  <= trig_pos_q - PRE_OFS;
            rd_left_q  <= RD_BEATS;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
        end else if (rd_load) begin
            if (rd_left_q != '0) begin
                rd_data_q  <= mem[rd_addr_q];
                rd_valid_q <= 1'b1;
                rd_last_q  <= (rd_left_q == RD_ONE);
                rd_addr_q  <= rd_addr_q + 1'b1;
                rd_left_q  <= rd_left_q - 1'b1;
            end else begin
                rd_valid_q <= 1'b0;
                rd_last_q  <= 1'b0;
            end
        end
    end

    assign rd_valid_o  = rd_valid_q;
    assign rd_data_o   = rd_data_q;
    assign rd_last_o   = rd_last_q;
    assign busy_o      = wr_en;
    assign triggered_o = triggered_q;
    assign done_o      = done_q;
    assign trig_pos_o  = trig_pos_q;

endmodule

// File: tb/tb_la_capture_core.sv
// Directed bench for la_capture_core (DEPTH=16, PRE_TRIG=4). Captures are
// table-driven; abort, no-trigger and reset-during-readout are hand sequences.
module tb_la_capture_core;
    localparam int DATA_W   = 8;
    localparam int TRIG_W   = 4;
    localparam int ADDR_W   = 4;
    localparam int PRE_TRIG = 4;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              arm_i;
    logic              abort_i;
    logic [DATA_W-1:0] data_i;
    logic [TRIG_W-1:0] trig_i;
    logic [TRIG_W-1:0] trig_mask_i;
    logic [TRIG_W-1:0] trig_val_i;
    logic [TRIG_W-1:0] trig_edge_i;
`ifdef LA_TRIG_COUNT_EN
    logic [15:0]       trig_cnt_i;
`endif
    logic              rd_start_i;
    logic              rd_ready_i;
    logic              rd_valid_o;
    logic [DATA_W-1:0] rd_data_o;
    logic              rd_last_o;
    logic              busy_o;
    logic              triggered_o;
    logic              done_o;
    logic [ADDR_W-1:0] trig_pos_o;

    la_capture_core #(
        .DATA_W  (DATA_W),
        .TRIG_W  (TRIG_W),
        .ADDR_W  (ADDR_W),
        .PRE_TRIG(PRE_TRIG)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .arm_i      (arm_i),
        .abort_i    (abort_i),
        .data_i     (data_i),
        .trig_i     (trig_i),
        .trig_mask_i(trig_mask_i),
        .trig_val_i (trig_val_i),
        .trig_edge_i(trig_edge_i),
`ifdef LA_TRIG_COUNT_EN
        .trig_cnt_i (trig_cnt_i),
`endif
        .rd_start_i (rd_start_i),
        .rd_ready_i (rd_ready_i),
        .rd_valid_o (rd_valid_o),
        .rd_data_o  (rd_data_o),
        .rd_last_o  (rd_last_o),
        .busy_o     (busy_o),
        .triggered_o(triggered_o),
        .done_o     (done_o),
        .trig_pos_o (trig_pos_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         id;
        logic [3:0] mask;
        logic [3:0] val;
        logic [3:0] edg;
        int         mode;
        int         exp_pos;
        int         exp_last;
        int         exp_first;
        bit         toggle;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Trigger input pattern for sample k of each scenario.
    function automatic logic [3:0] trig_pat(input int mode, input int k);
        case (mode)
            1:       return (k >= 10) ? 4'b0001 : 4'b0000;
            2:       return (k < 4) ? 4'b0001 : 4'b0000;
            3:       return (k < 7 || k >= 9) ? 4'b0010 : 4'b0000;
            4:       return 4'(k);
            6:       return (k == 5 || k == 8 || k == 11) ? 4'b0001 : 4'b0000;
            default: return 4'b0000;
        endcase
    endfunction

    // Arm and stream samples 0,1,2,...; last_k is the sample after which done_o rose (-1 if never).
    task automatic capture(input logic [3:0] mask, input logic [3:0] val, input logic [3:0] edg,
                           input int mode, input int max_k, output int last_k);
        trig_mask_i = mask;
        trig_val_i  = val;
        trig_edge_i = edg;
        trig_i      = trig_pat(mode, 0);
        data_i      = 8'd0;
        arm_i       = 1'b1;
        tick();
        arm_i = 1'b0;
        chk("arm busy", int'(busy_o), 1);
        chk("arm clears done", int'(done_o), 0);
        chk("arm clears triggered", int'(triggered_o), 0);
        last_k = -1;
        for (int k = 0; k < max_k; k++) begin
            data_i = 8'(k);
            trig_i = trig_pat(mode, k);
            tick();
            if (done_o) begin
                last_k = k;
                break;
            end
        end
    endtask

    // Read the whole buffer and compare against first, first+1, ...
    task automatic readout(input int first, input bit toggle);
        int         beats   = 0;
        int         cyc     = 0;
        int         lat     = 0;
        bit         holding = 1'b0;
        logic [7:0] held    = 8'd0;
        rd_ready_i = 1'b1;
        rd_start_i = 1'b1;
        tick();
        rd_start_i = 1'b0;
        lat = 1;
        while (!rd_valid_o && lat < 10) begin
            tick();
            lat++;
        end
        chk("rd latency", lat, 2);
        while (beats < 16 && cyc < 200) begin
            rd_ready_i = toggle ? (cyc % 2 == 1) : 1'b1;
            if (holding) begin
                chk("rd hold valid", int'(rd_valid_o), 1);
                chk("rd hold data", int'(rd_data_o), int'(held));
            end
            holding = 1'b0;
            if (rd_valid_o && rd_ready_i) begin
                chk($sformatf("rd data beat %0d", beats + 1), int'(rd_data_o), first + beats);
                chk($sformatf("rd last beat %0d", beats + 1), int'(rd_last_o), (beats == 15) ? 1 : 0);
                beats++;
            end else if (rd_valid_o) begin
                holding = 1'b1;
                held    = rd_data_o;
            end
            tick();
            cyc++;
        end
        rd_ready_i = 1'b0;
        chk("rd beat count", beats, 16);
        chk("rd end valid", int'(rd_valid_o), 0);
        chk("rd end done", int'(done_o), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int last_k;

        vecs[0] = '{id: 1, mask: 4'b0001, val: 4'b0001, edg: 4'b0000, mode: 1,
                    exp_pos: 10, exp_last: 21, exp_first: 6, toggle: 1'b0};
        vecs[1] = '{id: 3, mask: 4'b0010, val: 4'b0010, edg: 4'b0010, mode: 3,
                    exp_pos: 9, exp_last: 20, exp_first: 5, toggle: 1'b0};
        vecs[2] = '{id: 4, mask: 4'b0000, val: 4'b0000, edg: 4'b0000, mode: 4,
                    exp_pos: 4, exp_last: 15, exp_first: 0, toggle: 1'b1};
`ifdef LA_TRIG_COUNT_EN
        vecs[3] = '{id: 6, mask: 4'b0001, val: 4'b0001, edg: 4'b0000, mode: 6,
                    exp_pos: 11, exp_last: 22, exp_first: 7, toggle: 1'b0};
        trig_cnt_i = 16'd2;
`else
        vecs[3] = '{id: 6, mask: 4'b0001, val: 4'b0001, edg: 4'b0000, mode: 6,
                    exp_pos: 5, exp_last: 16, exp_first: 1, toggle: 1'b0};
`endif

        rst_i       = 1'b1;
        arm_i       = 1'b0;
        abort_i     = 1'b0;
        data_i      = '0;
        trig_i      = '0;
        trig_mask_i = '0;
        trig_val_i  = '0;
        trig_edge_i = '0;
        rd_start_i  = 1'b0;
        rd_ready_i  = 1'b0;
        tick();
        tick();
        chk("reset rd_valid", int'(rd_valid_o), 0);
        chk("reset rd_data", int'(rd_data_o), 0);
        chk("reset rd_last", int'(rd_last_o), 0);
        chk("reset busy", int'(busy_o), 0);
        chk("reset triggered", int'(triggered_o), 0);
        chk("reset done", int'(done_o), 0);
        chk("reset trig_pos", int'(trig_pos_o), 0);
        rst_i = 1'b0;
        tick();

        for (int i = 0; i < 4; i++) begin
            capture(vecs[i].mask, vecs[i].val, vecs[i].edg, vecs[i].mode, 40, last_k);
            chk($sformatf("t%0d trig_pos", vecs[i].id), int'(trig_pos_o), vecs[i].exp_pos);
            chk($sformatf("t%0d done sample", vecs[i].id), last_k, vecs[i].exp_last);
            chk($sformatf("t%0d triggered", vecs[i].id), int'(triggered_o), 1);
            chk($sformatf("t%0d busy", vecs[i].id), int'(busy_o), 0);
            readout(vecs[i].exp_first, vecs[i].toggle);
        end

        // Trigger condition only present during FILL: must keep waiting.
        capture(4'b0001, 4'b0001, 4'b0000, 2, 30, last_k);
        chk("t2 no done", last_k, -1);
        chk("t2 triggered", int'(triggered_o), 0);
        chk("t2 done", int'(done_o), 0);
        chk("t2 busy", int'(busy_o), 1);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        chk("t2 abort busy", int'(busy_o), 0);
        abort_i = 1'b1;
        arm_i   = 1'b1;
        tick();
        abort_i = 1'b0;
        arm_i   = 1'b0;
        chk("abort beats arm", int'(busy_o), 0);

        // Abort during POST.
        capture(4'b0000, 4'b0000, 4'b0000, 4, 9, last_k);
        chk("t5 in post triggered", int'(triggered_o), 1);
        chk("t5 in post busy", int'(busy_o), 1);
        chk("t5 in post trig_pos", int'(trig_pos_o), 4);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        chk("t5 abort busy", int'(busy_o), 0);
        chk("t5 abort triggered", int'(triggered_o), 0);
        chk("t5 abort done", int'(done_o), 0);

        // Asynchronous reset in the middle of a readout.
        capture(4'b0000, 4'b0000, 4'b0000, 4, 40, last_k);
        chk("t5r done sample", last_k, 15);
        rd_ready_i = 1'b1;
        rd_start_i = 1'b1;
        tick();
        rd_start_i = 1'b0;
        tick();
        tick();
        tick();
        chk("t5r streaming", int'(rd_valid_o), 1);
        #2;
        rst_i = 1'b1;
        #1;
        chk("t5r rst rd_valid", int'(rd_valid_o), 0);
        chk("t5r rst done", int'(done_o), 0);
        chk("t5r rst triggered", int'(triggered_o), 0);
        chk("t5r rst trig_pos", int'(trig_pos_o), 0);
        tick();
        rst_i      = 1'b0;
        rd_ready_i = 1'b0;
        tick();
        chk("t5r idle busy", int'(busy_o), 0);
        chk("t5r idle rd_valid", int'(rd_valid_o), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/la_capture_core.md
Name: la_capture_core

Overview:
- Parametrised successor to the single-probe GAO analyzer core: multi-bit data capture, multi-bit trigger with per-bit mask, value and edge mode, configurable pre-trigger depth.
- Adds a circular capture buffer and a valid/ready readout stream.
- Sits between the probed user logic (clk_i domain) and the JTAG control/readout logic.

Parameters:
- DATA_W, 8: width of captured sample.
- TRIG_W, 4: width of trigger input vector.
- ADDR_W, 9: buffer address width; DEPTH = 2**ADDR_W samples.
- PRE_TRIG, 64: samples kept before the trigger sample; legal range 0..DEPTH-1.

Ports:
- clk_i  in  1  sample clock.
- rst_i  in  1  asynchronous, active-high reset.
- arm_i  in  1  pulse; starts a capture.
- abort_i  in  1  pulse; returns to IDLE from any state.
- data_i  in  DATA_W  probed data.
- trig_i  in  TRIG_W  probed trigger signals.
- trig_mask_i  in  TRIG_W  1 = bit participates in trigger.
- trig_val_i  in  TRIG_W  required level (level mode) or target level (edge mode).
- trig_edge_i  in  TRIG_W  1 = edge mode for that bit, 0 = level mode.
- rd_start_i  in  1  pulse; begins readout (accepted in DONE only).
- rd_ready_i  in  1  consumer ready.
- rd_valid_o  out  1  readout data valid.
- rd_data_o  out  DATA_W  readout sample, oldest first.
- rd_last_o  out  1  final readout beat.
- busy_o  out  1  state is FILL, WAIT or POST.
- triggered_o  out  1  trigger seen in current capture.
- done_o  out  1  capture complete, buffer valid.
- trig_pos_o  out  ADDR_W  buffer address of the trigger sample.

Behaviour:
- Reset: state IDLE; all outputs 0; pointers, counters and trig_q cleared.
- trig_q is a register of trig_i, updated every cycle.
- Per-bit hit:
  - mask=0 -> 1.
  - Level mode -> trig_i==val.
  - Edge mode -> trig_i==val AND trig_q!=val.
- Trigger = AND of all bit hits. All-zero mask means trigger is true on every cycle.
- States:
  - IDLE: arm_i -> FILL.
  - FILL: on entry wr_ptr=0, count=0. Every FILL/WAIT/POST cycle writes data_i at wr_ptr, then wr_ptr+1 (wraps modulo DEPTH). Triggers are ignored. After PRE_TRIG writes -> WAIT. PRE_TRIG=0 goes straight to WAIT.
  - WAIT: writes continue circularly. On the trigger cycle that sample is written, trig_pos_o = its address, triggered_o=1, state -> POST.
  - POST: DEPTH-PRE_TRIG samples in total are stored, including the trigger sample. The cycle after the last write: done_o=1, state DONE.
  - DONE: arm_i -> FILL, clearing done_o and triggered_o. rd_start_i -> READ.
  - READ: DEPTH beats starting at address (trig_pos_o - PRE_TRIG) mod DEPTH, incrementing with wrap.
    - rd_valid_o first asserts exactly 2 cycles after rd_start_i.
    - A beat transfers when valid & ready. While ready is low, rd_valid_o and rd_data_o hold.
    - rd_last_o is high with the DEPTH-th beat. After it transfers -> DONE; done_o remains 1, so re-reading is allowed.
- arm_i is ignored in FILL, WAIT, POST and READ.
- abort_i in any state -> IDLE next cycle and clears triggered_o, done_o and rd_valid_o. Abort wins over a simultaneous arm_i or rd_start_i.
- rst_i mid-operation: immediate return to the reset state; buffer contents are don't-care.
- Buffer: single-port-write, single-port-read synchronous RAM of DEPTH x DATA_W.

Optional Feature:
- LA_TRIG_COUNT_EN.
- Defined:
  - Adds input trig_cnt_i [15:0].
  - In WAIT, trigger occurrences are counted. Capture triggers on occurrence trig_cnt_i+1 (0 = first). Earlier occurrences are stored as ordinary samples.
  - Occurrence counter clears on arm_i.
- Undefined: port absent; the first trigger occurrence in WAIT captures.

Test Plan:
All tests use DATA_W=8, TRIG_W=4, ADDR_W=4 (DEPTH=16), PRE_TRIG=4; data_i = samples written since arm (0,1,2,...).
1. Level trigger: mask=0001, val=0001; trig_i[0] rises at sample 10.
   -> trig_pos_o=10, done_o after sample 21.
   -> Readout 6..21, sample 10 at beat 5, rd_last_o on beat 16.
2. trig_i[0]=1 only during samples 0-3 (FILL), then 0.
   -> Stays WAIT; triggered_o=0, done_o=0, busy_o=1.
3. Edge mode: mask=0010, edge=0010, val=0010. trig_i[1] high from arm, low at sample 7, high at sample 9.
   -> Trigger at sample 9, not earlier; readout 5..20.
4. Mask=0000.
   -> Trigger on sample 4; readout 0..15. With rd_ready_i toggled 1/0 every cycle, all 16 values are delivered unchanged and in order.
5. abort_i during POST -> IDLE, triggered_o=0, done_o=0.
   rst_i asserted mid-READ -> rd_valid_o=0 immediately, state IDLE.
6. LA_TRIG_COUNT_EN defined, trig_cnt_i=2, level pulses at samples 5, 8, 11.
   -> trig_pos_o=11, readout 7..22.
